branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised dynamic branch predictor for the pipelined RV32I core. The IF stage does a combinational lookup with the fetch PC and gets a taken/not-taken prediction and a target. The EX stage writes the resolved outcome back one entry per cycle. The block is a direct-mapped branch target buffer (BTB) with a saturating counter per entry, an optional global-history index hash, and saturating performance counters. It replaces the fixed PC+4 default that IF uses for every branch.

## Interface
Parameters:
- ENTRIES, 64: number of BTB entries; power of two, minimum 4. IDX_W = $clog2(ENTRIES).
- CTR_W, 2: width of each saturating counter; minimum 1.
- ADDR_W, 32: PC width. TAG_W = ADDR_W - IDX_W - 2.

Ports:
- clk  in  1  clock; every state element updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- if_pc  in  ADDR_W  fetch PC; bits [1:0] ignored.
- pred_taken  out  1  prediction for if_pc; combinational.
- pred_target  out  ADDR_W  predicted next PC; combinational.
- pred_idx  out  IDX_W  index used for this lookup; IF carries it down the pipe.
- upd_valid  in  1  EX resolved a branch or jump this cycle.
- upd_pc  in  ADDR_W  PC of the resolved instruction.
- upd_idx  in  IDX_W  pred_idx that was captured at fetch for this instruction.
- upd_taken  in  1  resolved direction.
- upd_target  in  ADDR_W  resolved target address.
- upd_pred_taken  in  1  pred_taken that was captured at fetch.
- upd_pred_target  in  ADDR_W  pred_target that was captured at fetch.
- mispredict  out  1  combinational; the upd_* beat was mispredicted.
- perf_updates  out  32  registered count of upd_valid beats; saturating.
- perf_mispred  out  32  registered count of mispredicts; saturating.

## Operation
- Each entry holds: valid bit, tag[TAG_W], target[ADDR_W], ctr[CTR_W].
- Lookup:
  - tag = if_pc[ADDR_W-1:IDX_W+2].
  - hit = valid[pred_idx] && tag matches.
  - pred_taken = hit && ctr[pred_idx][CTR_W-1].
  - pred_target = stored target when pred_taken, otherwise if_pc + 4 (mod 2^ADDR_W).
- Index: pred_idx = if_pc[IDX_W+1:2], or the hashed form under BP_GHR_EN.
- mispredict = upd_valid && (upd_pred_taken != upd_taken || (upd_taken && upd_pred_target != upd_target)).
- Update on upd_valid, writing entry upd_idx:
  - Tag hit, taken: ctr increments, saturating at 2^CTR_W-1; target is overwritten with upd_target.
  - Tag hit, not taken: ctr decrements, saturating at 0; target unchanged.
  - Tag miss, taken: allocate. valid=1, tag from upd_pc, target=upd_target, ctr = 2^(CTR_W-1) (weakly taken). Any previous occupant is replaced.
  - Tag miss, not taken: no change.
- Performance counters:
  - perf_updates increments on every upd_valid.
  - perf_mispred increments when mispredict is high.
  - Both hold at 32'hFFFF_FFFF.

## Timing
- Lookup: zero latency, purely combinational from if_pc and the array state.
- Update: takes effect at the rising edge after upd_valid; it is visible to lookups from the next cycle onward.
- Lookup and update to the same entry in the same cycle: the lookup sees the pre-update state. There is no write-through.
- One update per cycle at most. There is no backpressure and no handshake; upd_valid is a strobe.
- Reset (rst=0 at a rising edge):
  - All valid bits clear.
  - All ctr reset to 2^(CTR_W-1)-1 (weakly not taken).
  - perf_updates = 0, perf_mispred = 0, GHR = 0.
  - upd_valid is ignored in the same cycle.
  - Asserting reset mid-stream discards any in-flight update.
- Output values after reset:
  - pred_taken = 0.
  - pred_target = if_pc + 4.
  - mispredict follows its inputs.
- CTR_W = 1: the counter is a single last-outcome bit; allocation sets it to 1.

## Configuration
- BP_GHR_EN defined:
  - An IDX_W-bit global history register (GHR) is added, reset to 0.
  - On each upd_valid it shifts left with upd_taken as the new LSB, using resolved (non-speculative) history.
  - pred_idx = if_pc[IDX_W+1:2] ^ GHR.
  - The tag is still taken from the PC.
- BP_GHR_EN undefined: no GHR is built; pred_idx = if_pc[IDX_W+1:2]. Otherwise the behaviour is identical.

## Test plan
Defaults unless stated: ENTRIES=64, CTR_W=2, BP_GHR_EN undefined.
- Reset, then lookup if_pc=0x100 -> pred_taken=0, pred_target=0x104, pred_idx=0, both perf counters 0.
- Update pc=0x100 taken, target=0x80, pred_taken=0, then lookup 0x100 -> pred_taken=1, pred_target=0x80, ctr=2, mispredict asserted during the update beat, perf_mispred=1.
- Two not-taken updates on 0x100, then lookup -> ctr=0, pred_taken=0. A third not-taken update keeps ctr=0 (saturation). Three taken updates -> ctr=3, and a fourth keeps ctr=3.
- Aliasing: 0x100 is allocated, then 0x200 is allocated taken at the same index (0x200 has idx 0 when ENTRIES=64) -> lookup 0x100 misses, returns 0x104; lookup 0x200 hits.
- Same-cycle lookup and update of 0x100 -> lookup returns the old state, and the new state appears the next cycle. Reset asserted with upd_valid=1 -> the entry stays invalid and the counters stay 0.
- With BP_GHR_EN defined: three taken updates -> GHR=3'b111 in the low bits, and lookup if_pc=0x100 gives pred_idx=0x07.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with per-entry saturating direction counters
// and saturating perf counters. Define BP_GHR_EN to XOR a global history register into the index.
module branch_predictor #(
  parameter int  ENTRIES = 64,
  parameter int  CTR_W   = 2,
  parameter int  ADDR_W  = 32,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int TAG_W   = ADDR_W - IDX_W - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              mispredict,
  output logic [31:0]       perf_updates,
  output logic [31:0]       perf_mispred
);

  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);

  logic              valid_q  [ENTRIES];
  logic              valid_d  [ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [ENTRIES];
  logic [CTR_W-1:0]  ctr_d    [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_d    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [ADDR_W-1:0] target_d [ENTRIES];

  logic [31:0] perf_updates_q, perf_updates_d;
  logic [31:0] perf_mispred_q, perf_mispred_d;

  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] lu_tag;
  logic [TAG_W-1:0] upd_tag;
  logic             lu_hit;
  logic             upd_hit;
  logic             unused_pc_bits;

  assign pc_idx  = if_pc[IDX_W+1:2];
  assign lu_tag  = if_pc[ADDR_W-1:IDX_W+2];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];
  // Index bits of upd_pc are redundant with upd_idx, which may carry history.
  assign unused_pc_bits = ^{if_pc[1:0], upd_pc[IDX_W+1:0]};

`ifdef BP_GHR_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;

  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid) ghr_d = {ghr_q[IDX_W-2:0], upd_taken};
  end

  always_ff @(posedge clk) begin
    if (!rst) ghr_q <= '0;
    else      ghr_q <= ghr_d;
  end

  assign pred_idx = pc_idx ^ ghr_q;
`else
  assign pred_idx = pc_idx;
`endif

  // Lookup reads only registered state, so a same-cycle update is never seen.
  assign lu_hit      = valid_q[pred_idx] && (tag_q[pred_idx] == lu_tag);
  assign pred_taken  = lu_hit && ctr_q[pred_idx][CTR_W-1];
  assign pred_target = pred_taken ? target_q[pred_idx] : if_pc + ADDR_W'(4);

  assign mispredict = upd_valid && ((upd_pred_taken != upd_taken) ||
                                    (upd_taken && (upd_pred_target != upd_target)));

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    valid_d        = valid_q;
    ctr_d          = ctr_q;
    tag_d          = tag_q;
    target_d       = target_q;
    perf_updates_d = perf_updates_q;
    perf_mispred_d = perf_mispred_q;

    if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (ctr_q[upd_idx] != CTR_MAX) ctr_d[upd_idx] = ctr_q[upd_idx] + CTR_W'(1);
          target_d[upd_idx] = upd_target;
        end else if (ctr_q[upd_idx] != '0) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] - CTR_W'(1);
        end
      end else if (upd_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
        ctr_d[upd_idx]    = CTR_WT;
      end

      if (perf_updates_q != '1) perf_updates_d = perf_updates_q + 32'd1;
    end

    if (mispredict && (perf_mispred_q != '1)) perf_mispred_d = perf_mispred_q + 32'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
      perf_updates_q <= '0;
      perf_mispred_q <= '0;
    end else begin
      valid_q        <= valid_d;
      ctr_q          <= ctr_d;
      perf_updates_q <= perf_updates_d;
      perf_mispred_q <= perf_mispred_d;
    end
  end

  // NOTE: tag and target arrays have no reset; valid_q gates every use of them, which keeps them plain RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

  assign perf_updates = perf_updates_q;
  assign perf_mispred = perf_mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard-driven directed bench for branch_predictor.
// Default build runs the BTB scenarios; with BP_GHR_EN defined it runs the history-index scenario.
`timescale 1ns/1ps
module tb_branch_predictor;

  localparam int ENTRIES = 64;
  localparam int CTR_W   = 2;
  localparam int ADDR_W  = 32;
  localparam int IDX_W   = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] if_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic [IDX_W-1:0]  pred_idx;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic [IDX_W-1:0]  upd_idx;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_pred_taken;
  logic [ADDR_W-1:0] upd_pred_target;
  logic              mispredict;
  logic [31:0]       perf_updates;
  logic [31:0]       perf_mispred;

  branch_predictor #(.ENTRIES(ENTRIES), .CTR_W(CTR_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_idx(pred_idx),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .perf_updates(perf_updates), .perf_mispred(perf_mispred)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic [5:0]  idx;
  } look_t;

  typedef struct packed {
    logic        tk;
    logic [31:0] tg;
    logic        ptk;
    logic [31:0] ptg;
    logic        m;
    logic        exp_tk;
    logic [31:0] exp_tg;
  } step_t;

  look_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    exp_upd  = 0;
  int    exp_mis  = 0;

  task automatic sb_push(input string name, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tg, input logic [5:0] idx);
    look_t e;
    e.name = name; e.pc = pc; e.taken = tk; e.target = tg; e.idx = idx;
    sb.push_back(e);
  endtask

  task automatic look(input logic [31:0] pc);
    @(negedge clk);
    if_pc = pc;
    #2;
  endtask

  // One update beat; the expected mispredict also feeds the perf-counter bookkeeping.
  task automatic upd(input logic [31:0] pc, input logic [5:0] idx, input logic tk,
                     input logic [31:0] tg, input logic ptk, input logic [31:0] ptg,
                     input logic exp_m, output logic mis_obs);
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = pc; upd_idx = idx; upd_taken = tk;
    upd_target = tg; upd_pred_taken = ptk; upd_pred_target = ptg;
    #2;
    mis_obs = mispredict;
    exp_upd++;
    if (exp_m) exp_mis++;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  task automatic test_reset;
    look_t e;
    @(negedge clk);
    upd_valid = 1'b0; upd_pc = 32'h100; upd_idx = 6'd0; upd_taken = 1'b0;
    upd_target = 32'h80; upd_pred_taken = 1'b1; upd_pred_target = 32'h0;
    #2;
    n_checks++;
    if (mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_mis_idle: got %b expected 0", mispredict); end
    upd_valid = 1'b1;
    #1;
    n_checks++;
    if (mispredict !== 1'b1) begin n_fail++; $display("FAIL reset_mis_follows: got %b expected 1", mispredict); end
    upd_taken = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    upd_valid = 1'b0;
    rst = 1'b1;
    sb_push("reset_0x100", 32'h100, 1'b0, 32'h104, 6'd0);
    sb_push("reset_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0, 6'd63);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      look(e.pc);
      n_checks++;
      if ({pred_taken, pred_target, pred_idx} !== {e.taken, e.target, e.idx}) begin
        n_fail++;
        $display("FAIL %s: got taken=%b target=%h idx=%0d, expected taken=%b target=%h idx=%0d",
                 e.name, pred_taken, pred_target, pred_idx, e.taken, e.target, e.idx);
      end
    end
    n_checks++;
    if (perf_updates !== 32'd0 || perf_mispred !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_updates, perf_mispred);
    end
  endtask

  task automatic test_allocate;
    look_t e;
    logic  m;
    upd(32'h100, 6'd0, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, m);
    n_checks++;
    if (m !== 1'b1) begin n_fail++; $display("FAIL alloc_mis: got %b expected 1", m); end
    upd(32'h108, 6'd2, 1'b0, 32'h200, 1'b0, 32'h10C, 1'b0, m);
    n_checks++;
    if (m !== 1'b0) begin n_fail++; $display("FAIL miss_nt_mis: got %b expected 0", m); end
    sb_push("alloc_hit", 32'h100, 1'b1, 32'h80, 6'd0);
    sb_push("miss_nt_no_alloc", 32'h108, 1'b0, 32'h10C, 6'd2);
    sb_push("alloc_neighbour", 32'h104, 1'b0, 32'h108, 6'd1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      look(e.pc);
      n_checks++;
      if ({pred_taken, pred_target, pred_idx} !== {e.taken, e.target, e.idx}) begin
        n_fail++;
        $display("FAIL %s: got taken=%b target=%h idx=%0d, expected taken=%b target=%h idx=%0d",
                 e.name, pred_taken, pred_target, pred_idx, e.taken, e.target, e.idx);
      end
    end
    n_checks++;
    if (perf_updates !== 32'(exp_upd) || perf_mispred !== 32'(exp_mis)) begin
      n_fail++;
      $display("FAIL alloc_perf: got %0d/%0d expected %0d/%0d", perf_updates, perf_mispred, exp_upd, exp_mis);
    end
  endtask

  // Entry 0x100 starts weakly taken (2) with target 0x80.
  task automatic test_counter;
    look_t e;
    logic  m;
    step_t steps [8];
    steps = '{
      '{1'b1, 32'h90, 1'b1, 32'h80,  1'b1, 1'b1, 32'h90},   // -> 3, target rewritten
      '{1'b1, 32'h90, 1'b1, 32'h90,  1'b0, 1'b1, 32'h90},   // stays 3
      '{1'b0, 32'h0,  1'b1, 32'h90,  1'b1, 1'b1, 32'h90},   // -> 2, target kept
      '{1'b0, 32'h0,  1'b1, 32'h90,  1'b1, 1'b0, 32'h104},  // -> 1
      '{1'b0, 32'h0,  1'b0, 32'h104, 1'b0, 1'b0, 32'h104},  // -> 0
      '{1'b0, 32'h0,  1'b0, 32'h104, 1'b0, 1'b0, 32'h104},  // stays 0
      '{1'b1, 32'hA0, 1'b0, 32'h104, 1'b1, 1'b0, 32'h104},  // -> 1
      '{1'b1, 32'hA0, 1'b0, 32'h104, 1'b1, 1'b1, 32'hA0}    // -> 2
    };
    for (int i = 0; i < 8; i++) begin
      upd(32'h100, 6'd0, steps[i].tk, steps[i].tg, steps[i].ptk, steps[i].ptg, steps[i].m, m);
      n_checks++;
      if (m !== steps[i].m) begin n_fail++; $display("FAIL ctr_mis_%0d: got %b expected %b", i, m, steps[i].m); end
      sb_push($sformatf("ctr_step_%0d", i), 32'h100, steps[i].exp_tk, steps[i].exp_tg, 6'd0);
      e = sb.pop_front();
      look(e.pc);
      n_checks++;
      if ({pred_taken, pred_target, pred_idx} !== {e.taken, e.target, e.idx}) begin
        n_fail++;
        $display("FAIL %s: got taken=%b target=%h idx=%0d, expected taken=%b target=%h idx=%0d",
                 e.name, pred_taken, pred_target, pred_idx, e.taken, e.target, e.idx);
      end
    end
    n_checks++;
    if (perf_updates !== 32'(exp_upd) || perf_mispred !== 32'(exp_mis)) begin
      n_fail++;
      $display("FAIL ctr_perf: got %0d/%0d expected %0d/%0d", perf_updates, perf_mispred, exp_upd, exp_mis);
    end
  endtask

  task automatic test_alias;
    look_t e;
    logic  m;
    upd(32'h200, 6'd0, 1'b1, 32'h40, 1'b0, 32'h204, 1'b1, m);
    n_checks++;
    if (m !== 1'b1) begin n_fail++; $display("FAIL alias_mis: got %b expected 1", m); end
    sb_push("alias_old_evicted", 32'h100, 1'b0, 32'h104, 6'd0);
    sb_push("alias_new_hit", 32'h200, 1'b1, 32'h40, 6'd0);
    upd(32'h100, 6'd0, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0, m);
    n_checks++;
    if (m !== 1'b0) begin n_fail++; $display("FAIL alias_nt_mis: got %b expected 0", m); end
    sb_push("alias_nt_miss_keeps", 32'h200, 1'b1, 32'h40, 6'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      look(e.pc);
      n_checks++;
      if ({pred_taken, pred_target, pred_idx} !== {e.taken, e.target, e.idx}) begin
        n_fail++;
        $display("FAIL %s: got taken=%b target=%h idx=%0d, expected taken=%b target=%h idx=%0d",
                 e.name, pred_taken, pred_target, pred_idx, e.taken, e.target, e.idx);
      end
    end
  endtask

  // Entry 0 holds 0x200 (ctr 2, target 0x40); entry 1 is empty.
  task automatic test_same_cycle;
    look_t e;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      upd_valid = 1'b1;
      if (k == 0) begin
        if_pc = 32'h200; upd_pc = 32'h200; upd_idx = 6'd0; upd_taken = 1'b0;
        upd_target = 32'h0; upd_pred_taken = 1'b1; upd_pred_target = 32'h40;
        sb_push("same_cycle_old_hit", 32'h200, 1'b1, 32'h40, 6'd0);
        sb_push("same_cycle_new_hit", 32'h200, 1'b0, 32'h204, 6'd0);
      end else begin
        if_pc = 32'h504; upd_pc = 32'h504; upd_idx = 6'd1; upd_taken = 1'b1;
        upd_target = 32'h700; upd_pred_taken = 1'b0; upd_pred_target = 32'h508;
        sb_push("same_cycle_old_alloc", 32'h504, 1'b0, 32'h508, 6'd1);
        sb_push("same_cycle_new_alloc", 32'h504, 1'b1, 32'h700, 6'd1);
      end
      exp_upd++;
      exp_mis++;
      #2;
      n_checks++;
      if (mispredict !== 1'b1) begin n_fail++; $display("FAIL same_cycle_mis_%0d: got %b expected 1", k, mispredict); end
      e = sb.pop_front();
      n_checks++;
      if ({pred_taken, pred_target, pred_idx} !== {e.taken, e.target, e.idx}) begin
        n_fail++;
        $display("FAIL %s: got taken=%b target=%h idx=%0d, expected taken=%b target=%h idx=%0d",
                 e.name, pred_taken, pred_target, pred_idx, e.taken, e.target, e.idx);
      end
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      e = sb.pop_front();
      look(e.pc);
      n_checks++;
      if ({pred_taken, pred_target, pred_idx} !== {e.taken, e.target, e.idx}) begin
        n_fail++;
        $display("FAIL %s: got taken=%b target=%h idx=%0d, expected taken=%b target=%h idx=%0d",
                 e.name, pred_taken, pred_target, pred_idx, e.taken, e.target, e.idx);
      end
    end
  endtask

  task automatic test_back_to_back;
    look_t e;
    logic  m;
    for (int i = 0; i < 4; i++) begin
      upd(32'h10 + 32'(4 * i), 6'(4 + i), 1'b1, 32'h1000 * 32'(i + 1), 1'b0, 32'h14 + 32'(4 * i), 1'b1, m);
      n_checks++;
      if (m !== 1'b1) begin n_fail++; $display("FAIL b2b_mis_%0d: got %b expected 1", i, m); end
      sb_push($sformatf("b2b_hit_%0d", i), 32'h10 + 32'(4 * i), 1'b1, 32'h1000 * 32'(i + 1), 6'(4 + i));
    end
    upd(32'h10, 6'd4, 1'b1, 32'h1000, 1'b1, 32'h1000, 1'b0, m);
    n_checks++;
    if (m !== 1'b0) begin n_fail++; $display("FAIL b2b_mis_correct: got %b expected 0", m); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      look(e.pc);
      n_checks++;
      if ({pred_taken, pred_target, pred_idx} !== {e.taken, e.target, e.idx}) begin
        n_fail++;
        $display("FAIL %s: got taken=%b target=%h idx=%0d, expected taken=%b target=%h idx=%0d",
                 e.name, pred_taken, pred_target, pred_idx, e.taken, e.target, e.idx);
      end
    end
    n_checks++;
    if (perf_updates !== 32'(exp_upd) || perf_mispred !== 32'(exp_mis)) begin
      n_fail++;
      $display("FAIL b2b_perf: got %0d/%0d expected %0d/%0d", perf_updates, perf_mispred, exp_upd, exp_mis);
    end
  endtask

  task automatic test_reset_mid;
    look_t e;
    @(negedge clk);
    rst = 1'b0;
    upd_valid = 1'b1; upd_pc = 32'h608; upd_idx = 6'd2; upd_taken = 1'b1;
    upd_target = 32'h900; upd_pred_taken = 1'b0; upd_pred_target = 32'h60C;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_upd = 0;
    exp_mis = 0;
    sb_push("rst_mid_discarded", 32'h608, 1'b0, 32'h60C, 6'd2);
    sb_push("rst_mid_cleared_b2b", 32'h10, 1'b0, 32'h14, 6'd4);
    sb_push("rst_mid_cleared_alias", 32'h200, 1'b0, 32'h204, 6'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      look(e.pc);
      n_checks++;
      if ({pred_taken, pred_target, pred_idx} !== {e.taken, e.target, e.idx}) begin
        n_fail++;
        $display("FAIL %s: got taken=%b target=%h idx=%0d, expected taken=%b target=%h idx=%0d",
                 e.name, pred_taken, pred_target, pred_idx, e.taken, e.target, e.idx);
      end
    end
    n_checks++;
    if (perf_updates !== 32'(exp_upd) || perf_mispred !== 32'(exp_mis)) begin
      n_fail++;
      $display("FAIL rst_mid_perf: got %0d/%0d expected %0d/%0d", perf_updates, perf_mispred, exp_upd, exp_mis);
    end
  endtask

  // History starts at 0; three taken beats walk the index 0 -> 1 -> 3 and leave GHR = 7.
  task automatic test_ghr;
    look_t      e;
    logic       m;
    logic [5:0] ghr;
    ghr = '0;
    for (int i = 0; i < 3; i++) begin
      upd(32'h100, ghr, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, m);
      n_checks++;
      if (m !== 1'b1) begin n_fail++; $display("FAIL ghr_mis_%0d: got %b expected 1", i, m); end
      ghr = {ghr[4:0], 1'b1};
    end
    sb_push("ghr_idx_0x100", 32'h100, 1'b0, 32'h104, 6'h07);
    sb_push("ghr_hashed_hit", 32'h11C, 1'b1, 32'h80, 6'h00);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      look(e.pc);
      n_checks++;
      if ({pred_taken, pred_target, pred_idx} !== {e.taken, e.target, e.idx}) begin
        n_fail++;
        $display("FAIL %s: got taken=%b target=%h idx=%0d, expected taken=%b target=%h idx=%0d",
                 e.name, pred_taken, pred_target, pred_idx, e.taken, e.target, e.idx);
      end
    end
    n_checks++;
    if (perf_updates !== 32'(exp_upd) || perf_mispred !== 32'(exp_mis)) begin
      n_fail++;
      $display("FAIL ghr_perf: got %0d/%0d expected %0d/%0d", perf_updates, perf_mispred, exp_upd, exp_mis);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    if_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_idx = '0; upd_taken = 1'b0;
    upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
    test_reset();
`ifdef BP_GHR_EN
    test_ghr();
`else
    test_allocate();
    test_counter();
    test_alias();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
